// File: rtl/avalon_burst_arbiter_pkg.sv
// Shared types and constants for the two-master Avalon burst arbiter.
package avalon_burst_arbiter_pkg;

    localparam int unsigned BURST_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StWburst,
        StRwait
    } arb_state_e;

endpackage

// File: rtl/avalon_burst_arbiter_if.sv
// Avalon-MM bursting bus; slave modport faces a master, master modport faces the SDRAM slave.
interface avalon_burst_arbiter_if
    import avalon_burst_arbiter_pkg::*;
#(
    parameter int unsigned BURST_W = BURST_W_DEFAULT
);
    logic [29:0]        address;
    logic [31:0]        writedata;
    logic [3:0]         byteenable;
    logic [BURST_W-1:0] burstcount;
    logic               read;
    logic               write;
    logic               waitrequest;
    logic               readdatavalid;
    logic [31:0]        readdata;

    modport master (
        output address, writedata, byteenable, burstcount, read, write,
        input  waitrequest, readdatavalid, readdata
    );

    modport slave (
        input  address, writedata, byteenable, burstcount, read, write,
        output waitrequest, readdatavalid, readdata
    );
endinterface

// File: rtl/avalon_burst_arbiter.sv
// Transaction-granular arbiter sharing one SDRAM Avalon port between a CPU (m0) and a DMA master
// (m1); a grant lasts until the last write beat is accepted or the last read beat returns.
module avalon_burst_arbiter
    import avalon_burst_arbiter_pkg::*;
#(
    parameter int unsigned FIXED_PRIO = 0,
    parameter int unsigned BURST_W    = BURST_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    avalon_burst_arbiter_if.slave  m0,
    avalon_burst_arbiter_if.slave  m1,
    avalon_burst_arbiter_if.master s
);

    arb_state_e         state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_q, last_d;
    logic [BURST_W-1:0] beats_q, beats_d;

    logic               req0, req1, winner, sel, fwd;
    logic               sel_read, sel_write;
    logic [BURST_W-1:0] sel_burst;
    arb_state_e         acc_state;
    logic [BURST_W-1:0] acc_beats;

    assign req0   = m0.read | m0.write;
    assign req1   = m1.read | m1.write;
    assign winner = (req0 & req1) ? ((FIXED_PRIO != 0) ? 1'b0 : ~last_q) : (req1 & ~req0);
    // Once a command is presented it stays locked to its owner until accepted.
    assign sel    = (state_q == StIdle) ? winner : owner_q;

    assign sel_read  = sel ? m1.read       : m0.read;
    assign sel_write = sel ? m1.write      : m0.write;
    assign sel_burst = sel ? m1.burstcount : m0.burstcount;

    assign s.address    = sel ? m1.address    : m0.address;
    assign s.writedata  = sel ? m1.writedata  : m0.writedata;
    assign s.byteenable = sel ? m1.byteenable : m0.byteenable;
    assign s.burstcount = sel_burst;

    assign m0.readdata = s.readdata;
    assign m1.readdata = s.readdata;

    // Where an accepted command leads; burstcount 0 behaves as a single beat.
    always_comb begin
        acc_state = StIdle;
        acc_beats = beats_q;
        if (sel_write) begin
            if (sel_burst > BURST_W'(1)) begin
                acc_state = StWburst;
                acc_beats = sel_burst - BURST_W'(1);
            end
        end else begin
            acc_state = StRwait;
            acc_beats = (sel_burst == '0) ? BURST_W'(1) : sel_burst;
        end
    end

    always_comb begin
        s.read  = 1'b0;
        s.write = 1'b0;
        fwd     = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                StIdle, StHold: begin
                    s.read  = sel_read;
                    s.write = sel_write;
                    fwd     = 1'b1;
                end
                StWburst: begin
                    s.write = sel_write;
                    fwd     = 1'b1;
                end
                StRwait: fwd = 1'b0;
            endcase
        end
        m0.waitrequest   = (fwd && !sel) ? s.waitrequest : 1'b1;
        m1.waitrequest   = (fwd &&  sel) ? s.waitrequest : 1'b1;
        m0.readdatavalid = rst_n && (state_q == StRwait) && s.readdatavalid && !owner_q;
        m1.readdatavalid = rst_n && (state_q == StRwait) && s.readdatavalid &&  owner_q;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        beats_d = beats_q;
        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    owner_d = winner;
                    if (!s.waitrequest) begin
                        last_d  = winner;
                        state_d = acc_state;
                        beats_d = acc_beats;
                    end else begin
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (!(sel_read || sel_write)) begin
                    state_d = StIdle;
                end else if (!s.waitrequest) begin
                    last_d  = owner_q;
                    state_d = acc_state;
                    beats_d = acc_beats;
                end
            end
            StWburst: begin
                if (sel_write && !s.waitrequest) begin
                    beats_d = beats_q - BURST_W'(1);
                    if (beats_q == BURST_W'(1)) state_d = StIdle;
                end
            end
            StRwait: begin
                if (s.readdatavalid) begin
                    beats_d = beats_q - BURST_W'(1);
                    if (beats_q == BURST_W'(1)) state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            beats_q <= beats_d;
        end
    end

endmodule

// File: tb/tb_avalon_burst_arbiter.sv
// Bench: round-robin and fixed-priority arbiters driven side by side, checked every cycle
// against a transaction-level model plus directed literal expectations.
module tb_avalon_burst_arbiter;

    localparam int BW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [29:0] st_addr  [2];
    logic [31:0] st_wdata [2];
    logic [3:0]  st_be    [2];
    logic [3:0]  st_bc    [2];
    logic        st_rd    [2];
    logic        st_wr    [2];
    logic        s_wait, s_rdv;
    logic [31:0] s_rdata;

    logic        o_sr [2], o_sw [2];
    logic [29:0] o_sa [2];
    logic [31:0] o_sd [2];
    logic [3:0]  o_sb [2], o_sc [2];
    logic        o_wr [2][2], o_rv [2][2];
    logic [31:0] o_rd [2][2];

    avalon_burst_arbiter_if #(.BURST_W(BW)) mi [4] ();
    avalon_burst_arbiter_if #(.BURST_W(BW)) si [2] ();

    avalon_burst_arbiter #(.FIXED_PRIO(0), .BURST_W(BW)) dut_rr (
        .clk(clk), .rst_n(rst_n), .m0(mi[0]), .m1(mi[1]), .s(si[0])
    );
    avalon_burst_arbiter #(.FIXED_PRIO(1), .BURST_W(BW)) dut_fp (
        .clk(clk), .rst_n(rst_n), .m0(mi[2]), .m1(mi[3]), .s(si[1])
    );

    for (genvar k = 0; k < 2; k++) begin : g_dut
        assign si[k].waitrequest   = s_wait;
        assign si[k].readdatavalid = s_rdv;
        assign si[k].readdata      = s_rdata;
        assign o_sr[k] = si[k].read;
        assign o_sw[k] = si[k].write;
        assign o_sa[k] = si[k].address;
        assign o_sd[k] = si[k].writedata;
        assign o_sb[k] = si[k].byteenable;
        assign o_sc[k] = si[k].burstcount;
        for (genvar i = 0; i < 2; i++) begin : g_m
            assign mi[2*k+i].address    = st_addr[i];
            assign mi[2*k+i].writedata  = st_wdata[i];
            assign mi[2*k+i].byteenable = st_be[i];
            assign mi[2*k+i].burstcount = st_bc[i];
            assign mi[2*k+i].read       = st_rd[i];
            assign mi[2*k+i].write      = st_wr[i];
            assign o_wr[k][i] = mi[2*k+i].waitrequest;
            assign o_rv[k][i] = mi[2*k+i].readdatavalid;
            assign o_rd[k][i] = mi[2*k+i].readdata;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t: got %h expected %h", nm, k, $time, act, exp);
        end
    endtask

    // Model: who holds the port (-1 free), who was served last, beats still owed.
    int own [2]     = '{-1, -1};
    int served [2]  = '{1, 1};
    int rd_left [2] = '{0, 0};
    int wr_left [2] = '{0, 0};

    function automatic int gnt_of(input int k);
        logic r0, r1;
        r0 = st_rd[0] | st_wr[0];
        r1 = st_rd[1] | st_wr[1];
        if (!rst_n) return -1;
        if (own[k] >= 0) return own[k];
        if (r0 && r1) return (k == 1) ? 0 : ((served[k] == 0) ? 1 : 0);
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int g, b;
            g = gnt_of(k);
            if (!rst_n) begin
                own[k] = -1; served[k] = 1; rd_left[k] = 0; wr_left[k] = 0;
            end else if (rd_left[k] > 0) begin
                if (s_rdv) begin
                    rd_left[k]--;
                    if (rd_left[k] == 0) own[k] = -1;
                end
            end else if (wr_left[k] > 0) begin
                if (st_wr[own[k]] && !s_wait) begin
                    wr_left[k]--;
                    if (wr_left[k] == 0) own[k] = -1;
                end
            end else if (g >= 0) begin
                if (!(st_rd[g] || st_wr[g])) own[k] = -1;
                else if (s_wait) own[k] = g;
                else begin
                    served[k] = g;
                    b = (st_bc[g] == 0) ? 1 : int'(st_bc[g]);
                    if (st_rd[g]) begin rd_left[k] = b; own[k] = g; end
                    else if (b > 1) begin wr_left[k] = b - 1; own[k] = g; end
                    else own[k] = -1;
                end
            end
        end
    end

    int dut_acc [2][$];
    int cnt_rv [2][2];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int g;
            logic esr, esw, ew;
            g = gnt_of(k);
            esr = 1'b0; esw = 1'b0;
            if (rst_n && rd_left[k] == 0) begin
                if (wr_left[k] > 0) esw = st_wr[g];
                else if (g >= 0) begin esr = st_rd[g]; esw = st_wr[g]; end
            end
            chk("s_read", k, o_sr[k], esr);
            chk("s_write", k, o_sw[k], esw);
            if (esr || esw) begin
                chk("s_address", k, o_sa[k], st_addr[g]);
                chk("s_burstcount", k, o_sc[k], st_bc[g]);
                if (esw) begin
                    chk("s_writedata", k, o_sd[k], st_wdata[g]);
                    chk("s_byteenable", k, o_sb[k], st_be[g]);
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (!rst_n || rd_left[k] > 0 || g >= 0) begin
                    ew = (rst_n && rd_left[k] == 0 && g == i) ? s_wait : 1'b1;
                    chk($sformatf("m%0d_waitrequest", i), k, o_wr[k][i], ew);
                end
                chk($sformatf("m%0d_readdatavalid", i), k, o_rv[k][i],
                    rst_n && rd_left[k] > 0 && own[k] == i && s_rdv);
                chk($sformatf("m%0d_readdata", i), k, o_rd[k][i], s_rdata);
                if (o_rv[k][i]) cnt_rv[k][i]++;
            end
            if (rst_n && (o_sr[k] || o_sw[k]) && !s_wait)
                dut_acc[k].push_back(o_wr[k][0] ? 1 : 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            st_rd[i] = 1'b0; st_wr[i] = 1'b0; st_addr[i] = '0;
            st_wdata[i] = '0; st_be[i] = 4'hF; st_bc[i] = 4'd1;
        end
        s_wait = 1'b0; s_rdv = 1'b0; s_rdata = '0;
        step(); step();
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            dut_acc[k].delete();
            cnt_rv[k][0] = 0; cnt_rv[k][1] = 0;
        end
    endtask

    task automatic chk_acc(input string nm, input int k, input int n, input int e [5]);
        chk({nm, "_len"}, k, dut_acc[k].size(), n);
        for (int j = 0; j < n && j < dut_acc[k].size(); j++)
            chk($sformatf("%s_%0d", nm, j), k, dut_acc[k][j], e[j]);
    endtask

    int exp_rr [5] = '{0, 1, 0, 1, 1};
    int exp_fp [5] = '{0, 0, 0, 0, 1};
    int exp_lk [5] = '{0, 1, 0, 0, 0};
    int exp_wb [5] = '{1, 1, 1, 0, 0};
    int wpat [5]   = '{1, 0, 1, 0, 0};

    initial begin
        reset_dut();

        // Single-master read burst.
        st_rd[0] = 1'b1; st_addr[0] = 30'h100; st_bc[0] = 4'd4;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("t1_addr", k, o_sa[k], 32'h100);
            chk("t1_grant", k, o_wr[k][0], 1'b0);
        end
        step();
        st_rd[0] = 1'b0;
        step(); step(); step();
        s_rdv = 1'b1;
        for (int b = 0; b < 4; b++) begin
            s_rdata = 32'hD000 + b;
            step();
        end
        s_rdv = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("t1_m0_beats", k, cnt_rv[k][0], 4);
            chk("t1_m1_beats", k, cnt_rv[k][1], 0);
        end
        st_wr[1] = 1'b1; st_addr[1] = 30'h180; st_wdata[1] = 32'h1234;
        @(negedge clk);
        for (int k = 0; k < 2; k++) chk("t1_idle_after", k, o_wr[k][1], 1'b0);
        step();
        st_wr[1] = 1'b0;
        step();

        // Contested single-beat writes: round-robin versus fixed priority.
        reset_dut();
        st_wr[0] = 1'b1; st_addr[0] = 30'h10; st_wdata[0] = 32'hAAAA;
        st_wr[1] = 1'b1; st_addr[1] = 30'h20; st_wdata[1] = 32'hBBBB; st_be[1] = 4'h3;
        repeat (4) step();
        st_wr[0] = 1'b0;
        step();
        st_wr[1] = 1'b0;
        step();
        chk_acc("t2_rr", 0, 5, exp_rr);
        chk_acc("t2_fp", 1, 5, exp_fp);

        // Stalled read stays locked while m1 raises a request.
        reset_dut();
        st_rd[0] = 1'b1; st_addr[0] = 30'h200; st_bc[0] = 4'd2; s_wait = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                st_wr[1] = 1'b1; st_addr[1] = 30'h300; st_bc[1] = 4'd1; st_wdata[1] = 32'h33;
            end
            @(negedge clk);
            for (int k = 0; k < 2; k++) chk("t4_locked_addr", k, o_sa[k], 32'h200);
            step();
        end
        s_wait = 1'b0;
        step();
        st_rd[0] = 1'b0;
        step();
        s_rdv = 1'b1; s_rdata = 32'h1;
        step();
        s_rdata = 32'h2;
        step();
        s_rdv = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("t4_m1_granted", k, o_wr[k][1], 1'b0);
            chk("t4_m0_blocked", k, o_wr[k][0], 1'b1);
        end
        step();
        st_wr[1] = 1'b0;
        step();
        for (int k = 0; k < 2; k++) chk_acc("t4_order", k, 2, exp_lk);

        // m1 write burst of 3 under a toggling waitrequest.
        reset_dut();
        st_wr[1] = 1'b1; st_addr[1] = 30'h40; st_bc[1] = 4'd3;
        for (int c = 0; c < 5; c++) begin
            s_wait = wpat[c];
            st_wdata[1] = 32'hA0 + c;
            if (c == 1) begin
                st_wr[0] = 1'b1; st_addr[0] = 30'h50; st_bc[0] = 4'd1; st_wdata[0] = 32'h55;
            end
            @(negedge clk);
            if (c >= 1)
                for (int k = 0; k < 2; k++) chk("t5_m0_blocked", k, o_wr[k][0], 1'b1);
            step();
        end
        for (int k = 0; k < 2; k++) chk_acc("t5_beats", k, 3, exp_wb);
        st_wr[1] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("t5_m0_next", k, o_wr[k][0], 1'b0);
            chk("t5_m0_addr", k, o_sa[k], 32'h50);
        end
        step();
        st_wr[0] = 1'b0;
        step();

        // Reset in the middle of a read; stray beats must be dropped.
        reset_dut();
        st_rd[0] = 1'b1; st_addr[0] = 30'h500; st_bc[0] = 4'd4;
        step();
        st_rd[0] = 1'b0; s_rdv = 1'b1; s_rdata = 32'hBEEF;
        step(); step();
        s_rdv = 1'b0;
        rst_n = 1'b0; st_rd[0] = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("t6_rst_sread", k, o_sr[k], 1'b0);
            chk("t6_rst_wr0", k, o_wr[k][0], 1'b1);
            chk("t6_rst_wr1", k, o_wr[k][1], 1'b1);
        end
        step();
        rst_n = 1'b1; st_rd[0] = 1'b0; s_rdv = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                chk("t6_stray_m0", k, o_rv[k][0], 1'b0);
                chk("t6_stray_m1", k, o_rv[k][1], 1'b0);
            end
            step();
        end
        s_rdv = 1'b0;
        st_rd[1] = 1'b1; st_addr[1] = 30'h600; st_bc[1] = 4'd1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("t6_m1_grant", k, o_wr[k][1], 1'b0);
            chk("t6_m1_addr", k, o_sa[k], 32'h600);
        end
        step();
        st_rd[1] = 1'b0; s_rdv = 1'b1; s_rdata = 32'h6666;
        step();
        s_rdv = 1'b0;
        step();
        for (int k = 0; k < 2; k++) begin
            chk("t6_m0_beats", k, cnt_rv[k][0], 2);
            chk("t6_m1_beats", k, cnt_rv[k][1], 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
